// File: rtl/rf_pkg.sv
// Shared register-file types: address/data widths and the writeback request
// record used by the write-port arbiter, the RegFile wrapper and the issue stage.
package rf_pkg;

   localparam int RF_AW   = 5;
   localparam int RF_DW   = 32;
   localparam int RF_NREG = 32;

   typedef logic [RF_AW-1:0] rf_addr_t;
   typedef logic [RF_DW-1:0] rf_data_t;

   typedef struct packed {
      logic     valid;
      rf_addr_t addr;
      rf_data_t data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus between writeback requesters / issue logic (master) and the register-file
// write-port arbiter (slave), including the scoreboard and pointer debug view.
interface rf_wb_arbiter_if
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i].
   // req_ready is combinational and one-hot; a waiting requester keeps addr/data
   // stable until granted, and may drop valid without committing anything.
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;

   logic               rf_we;
   logic [AW-1:0]      rf_waddr;
   logic [DW-1:0]      rf_wdata;

   logic               sb_set;
   logic [AW-1:0]      sb_addr;
   logic [2**AW-1:0]   busy;

   logic [PW-1:0]      dbg_ptr;

   modport master (
      output req_valid, req_addr, req_data, sb_set, sb_addr,
      input  req_ready, rf_we, rf_waddr, rf_wdata, busy, dbg_ptr
   );

   modport slave (
      input  req_valid, req_addr, req_data, sb_set, sb_addr,
      output req_ready, rf_we, rf_waddr, rf_wdata, busy, dbg_ptr
   );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// One-hot grant generator: round-robin with a rotating pointer by default,
// fixed lowest-index priority when RFARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
   parameter  int NREQ = 3,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   ptr
);

   logic [NREQ-1:0] raw;

`ifdef RFARB_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last (winning) assignment.
   always_comb begin
      raw = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            raw    = '0;
            raw[i] = 1'b1;
         end
      end
   end

   assign ptr = '0;

   logic unused_fixed;
   assign unused_fixed = ^{clk, advance};
`else
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] gidx;

   // Scan offsets from far to near so the index closest to ptr wins.
   always_comb begin
      raw  = '0;
      gidx = ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr_q) + k) % NREQ]) begin
            raw                             = '0;
            raw[(int'(ptr_q) + k) % NREQ]   = 1'b1;
            gidx                            = PW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`endif

   assign grant = rst ? '0 : raw;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with registered write stage and pending-write
// scoreboard. Define RFARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
) (
   input  logic          clk,
   input  logic          rst,
   rf_wb_arbiter_if.slave bus
);

   localparam int NB = 2**AW;

   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [AW-1:0]   g_addr;
   logic [DW-1:0]   g_data;

   logic            we_q;
   logic [AW-1:0]   waddr_q;
   logic [DW-1:0]   wdata_q;
   logic [NB-1:0]   busy_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req_valid),
      .advance (xfer),
      .grant   (grant),
      .ptr     (bus.dbg_ptr)
   );

   assign bus.req_ready = grant;
   assign xfer          = |(bus.req_valid & grant);

   always_comb begin
      g_addr = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_addr = bus.req_addr[i*AW +: AW];
            g_data = bus.req_data[i*DW +: DW];
         end
      end
   end

   // A granted write to $0 is consumed here so the register file never sees it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else if (xfer) begin
         we_q    <= (g_addr != '0);
         waddr_q <= g_addr;
         wdata_q <= g_data;
      end else begin
         we_q    <= 1'b0;
      end
   end

   // A fresh claim beats the retiring write to the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int a = 1; a < NB; a++) begin
            if (bus.sb_set && bus.sb_addr == AW'(a))  busy_q[a] <= 1'b1;
            else if (we_q && waddr_q == AW'(a))      busy_q[a] <= 1'b0;
         end
      end
   end

   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NB   = 2**AW;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int               m_ptr;
  logic             m_we;
  logic [AW-1:0]    m_waddr;
  logic [DW-1:0]    m_wdata;
  logic [NB-1:0]    m_busy;
  logic [NREQ-1:0]  m_last_grant;
  logic [AW+DW-1:0] exp_q[$];
  logic [NREQ-1:0]  m_g;
  logic [AW-1:0]    m_a;
  logic [DW-1:0]    m_d;

  function automatic logic [NREQ-1:0] model_grant(logic [NREQ-1:0] v, int p);
    logic [NREQ-1:0] r;
    r = '0;
`ifdef RFARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) begin r = '0; r[i] = 1'b1; end
    if (p < 0) r = '0;
`else
    for (int k = NREQ - 1; k >= 0; k--) if (v[(p + k) % NREQ]) begin r = '0; r[(p + k) % NREQ] = 1'b1; end
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_busy = '0; m_last_grant = '0;
      exp_q.delete();
    end else begin
      m_g = model_grant(bus.req_valid, m_ptr);
      m_last_grant = m_g;
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (bus.sb_set && bus.sb_addr != '0) m_busy[bus.sb_addr] = 1'b1;
      m_we = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (m_g[i]) begin
          m_a = bus.req_addr[i*AW +: AW];
          m_d = bus.req_data[i*DW +: DW];
          m_we = (m_a != '0);
          m_waddr = m_a;
          m_wdata = m_d;
          m_ptr = (i + 1) % NREQ;
          if (m_a != '0) exp_q.push_back({m_a, m_d});
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [NREQ-1:0]  c_ready;
  logic [AW+DW-1:0] c_wr;

  always @(negedge clk) begin
    c_ready = rst ? '0 : model_grant(bus.req_valid, m_ptr);
    check("ready", 64'(bus.req_ready), 64'(c_ready));
    check("rf_we", 64'(bus.rf_we), 64'(m_we));
    check("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
    check("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
    check("busy", 64'(bus.busy), 64'(m_busy));
    if (bus.rf_we === 1'b1 && !rst) begin
      if (exp_q.size() == 0) begin
        check("wstream_avail", 64'(0), 64'(1));
      end else begin
        c_wr = exp_q.pop_front();
        check("wstream", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(c_wr));
      end
    end
    check("wstream_drain", 64'(exp_q.size()), 64'(0));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.sb_set    = 1'b0;
    bus.sb_addr   = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic sb(input logic s, input logic [AW-1:0] a);
    bus.sb_set  = s;
    bus.sb_addr = a;
  endtask

`ifdef RFARB_FIXED_PRIO_EN
  int seq_idx[6] = '{0, 0, 0, 0, 0, 0};
`else
  int seq_idx[6] = '{0, 1, 2, 0, 1, 2};
`endif

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_we", 64'(bus.rf_we), 64'(0));
    cyc();

    // single request
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_ready", 64'(bus.req_ready), 64'(3'b001));
    cyc(); idle();
    @(negedge clk);
    check("t1_we", 64'(bus.rf_we), 64'(1));
    check("t1_waddr", 64'(bus.rf_waddr), 64'(5));
    check("t1_wdata", 64'(bus.rf_wdata), 64'(32'hDEADBEEF));

    // requester 2 alone, bringing the round-robin pointer back to 0
    cyc();
    set_req(2, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    check("t1b_ready", 64'(bus.req_ready), 64'(3'b100));
    cyc(); idle();

    // all three valid for six cycles
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(10 + i), DW'(32'hA0 + i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_grant", 64'(bus.req_ready), 64'(NREQ'(1) << seq_idx[k]));
      if (k > 0) check("t2_waddr", 64'(bus.rf_waddr), 64'(10 + seq_idx[k-1]));
      cyc();
    end
    idle();
    @(negedge clk);
    check("t2_waddr_last", 64'(bus.rf_waddr), 64'(10 + seq_idx[5]));

    // write to $0 is accepted but suppressed
    cyc();
    set_req(1, 1'b1, 5'd0, 32'h12345678);
    @(negedge clk);
    check("t3_ready", 64'(bus.req_ready), 64'(3'b010));
    cyc(); idle();
    @(negedge clk);
    check("t3_we", 64'(bus.rf_we), 64'(0));

    // scoreboard round trip
    cyc(); sb(1'b1, 5'd7);
    cyc(); sb(1'b0, 5'd0);
    @(negedge clk);
    check("t4_busy_set", 64'(bus.busy[7]), 64'(1));
    cyc(); set_req(0, 1'b1, 5'd7, 32'h77);
    cyc(); idle();
    @(negedge clk);
    check("t4_we", 64'(bus.rf_we), 64'(1));
    check("t4_busy_pending", 64'(bus.busy[7]), 64'(1));
    cyc();
    @(negedge clk);
    check("t4_busy_clr", 64'(bus.busy[7]), 64'(0));

    // claim of $0 never marks anything busy
    cyc(); sb(1'b1, 5'd0);
    cyc(); sb(1'b0, 5'd0);
    @(negedge clk);
    check("t5_busy_zero", 64'(bus.busy), 64'(0));

    // claim coinciding with retirement keeps the register busy
    cyc(); sb(1'b1, 5'd7);
    cyc(); sb(1'b0, 5'd0); set_req(0, 1'b1, 5'd7, 32'h78);
    cyc(); idle(); sb(1'b1, 5'd7);
    @(negedge clk);
    check("t4b_we", 64'(bus.rf_we), 64'(1));
    cyc(); sb(1'b0, 5'd0);
    @(negedge clk);
    check("t4b_busy_kept", 64'(bus.busy[7]), 64'(1));

    // asynchronous reset mid-operation
    cyc(); set_req(0, 1'b1, 5'd3, 32'h33);
    cyc(); idle(); set_req(1, 1'b1, 5'd4, 32'h44);
    #2;
    check("t6_pre_we", 64'(bus.rf_we), 64'(1));
    check("t6_pre_busy", 64'(bus.busy), 64'(32'h00000080));
    check("t6_pre_ready", 64'(bus.req_ready), 64'(3'b010));
    rst = 1'b1;
    #1;
    check("t6_rst_we", 64'(bus.rf_we), 64'(0));
    check("t6_rst_busy", 64'(bus.busy), 64'(0));
    check("t6_rst_ready", 64'(bus.req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    set_req(0, 1'b1, 5'd20, 32'h20);
    set_req(2, 1'b1, 5'd22, 32'h22);
    @(negedge clk);
    check("t6_first_grant", 64'(bus.req_ready), 64'(3'b001));
    cyc(); idle();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || m_last_grant[i]) begin
          if ($urandom_range(0, 99) < 60)
            set_req(i, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom));
          else
            bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 5) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      sb($urandom_range(0, 99) < 30, AW'($urandom_range(0, 7)));
    end
    cyc(); idle();
    repeat (3) cyc();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 register file. Up to NREQ writeback sources (ALU, load unit, mul/div) compete for the register file's single write port. The block grants one source per cycle and drives a registered write strobe, address and data into the register file. It also tracks a busy bit per register so issue logic can stall on pending destinations.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i, packed, slice i at [i*AW +: AW]
- req_data  in  NREQ*DW  write data of requester i, packed, slice i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer i occurs when req_valid[i] & req_ready[i]
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  AW  register-file write address, registered
- rf_wdata  out  DW  register-file write data, registered
- sb_set  in  1  issue logic claims a destination this cycle
- sb_addr  in  AW  destination being claimed
- busy  out  2**AW  per-register pending-write bits, registered

## Operation
- Arbitration:
  - req_ready is combinational from req_valid and the priority pointer.
  - At most one bit is set, and only for a valid requester.
  - All bits are 0 while rst is high.
- Round-robin scheme:
  - Search starts at index ptr and wraps modulo NREQ.
  - After a transfer from index g, ptr becomes (g+1) mod NREQ.
  - ptr is unchanged in cycles with no transfer.
- Output stage:
  - On a transfer, rf_we, rf_waddr and rf_wdata load at the next edge from the granted slice.
  - With no transfer, rf_we loads 0; rf_waddr and rf_wdata hold.
- Address 0 handling:
  - A transfer to address 0 is accepted (ready asserted) but loads rf_we=0.
  - The register file never sees a write to $0.
- The output stage never stalls, because the register file accepts every cycle. Throughput is one write per cycle.
- Scoreboard:
  - busy[a] sets at the edge where sb_set=1 and sb_addr=a, for a≠0.
  - busy[a] clears at the edge where rf_we=1 and rf_waddr=a.
  - Set and clear of the same address at the same edge: set wins, because a new producer has been claimed.
  - busy[0] is constant 0.
  - A requester may be valid regardless of busy; the scoreboard is advisory to issue logic.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, ptr=0.
- Reset asserted mid-operation discards the in-flight output-stage write (rf_we drops immediately) and clears all busy bits.

## Timing
- Request to rf_we: 1 cycle. Requester i valid at edge k-1→k gives rf_we high during cycle k+1, and the register file captures at the end of cycle k+1.
- busy clears at the same edge the register file captures the write.
- Earliest cycle issue logic sees busy[a]=0 is cycle k+2.
- A requester holding valid across cycles must keep addr and data stable until it is granted. Valid may drop before a grant; nothing is committed in that case.
- Worst-case wait for any continuously valid requester is NREQ-1 cycles in round-robin mode.
- Simultaneous valid from all NREQ requesters with ptr=p: the grant order is p, p+1, …, wrapping.

## Configuration
- RFARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest valid index always wins.
  - ptr is not implemented.
  - Starvation of high indices is permitted.
- RFARB_FIXED_PRIO_EN undefined: round-robin as described under Operation. This is the default.

## Structure
- Package rf_pkg holds:
  - constants RF_AW=5, RF_DW=32, RF_NREG=32;
  - typedefs rf_addr_t and rf_data_t;
  - the wb_req_t struct (valid, addr, data), shared with the RegFile wrapper and the issue stage.
- One sub-module, rr_arbiter:
  - Parameterised by NREQ.
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant, internal ptr.
  - It contains the RFARB_FIXED_PRIO_EN switch.
- The top level holds the output registers and the scoreboard.

## Test plan
- Reset, then a single request: req_valid=001, addr=5, data=0xDEADBEEF. Required: ready=001 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- All three valid for 6 cycles from ptr=0. Required: grants 001,010,100,001,010,100; rf_waddr sequence follows the grant order one cycle later. With the macro defined, grant stays 001.
- Requester 1 writes addr=0, data=0x12345678. Required: ready[1]=1 and rf_we stays 0 on the following cycle.
- Scoreboard round trip:
  - sb_set with addr=7 → busy[7]=1 next cycle.
  - Requester 0 then writes addr 7 → busy[7]=0 at the edge where rf_we=1.
  - sb_set of addr 7 in that same cycle → busy[7] stays 1.
- sb_set with addr=0. Required: busy stays all-zero.
- Assert rst while rf_we=1 and busy=0x00000080. Required: rf_we=0, busy=0, req_ready=0 immediately without waiting for a clock edge; after release the first grant goes to index 0.
